// File: rtl/snoop_responder.sv
// snoop_responder: answers bus snoops against a set-associative MESI tag store.
// A request is captured in IDLE, looked up for one cycle, optionally held in WB
// while a modified line is written back, then answered in a one-cycle RESPOND.
// Optional statistics counters are built only when SNOOP_STATS_EN is defined.
module snoop_responder #(
  parameter int i_size   = 32,
  parameter int c_size   = 24,
  parameter int d_size   = 6,
  parameter int protocol = 2,
  parameter int a_size   = 8,
  localparam int IW = c_size - d_size - $clog2(a_size),
  localparam int TW = i_size - IW - d_size,
  localparam int WW = (a_size > 1) ? $clog2(a_size) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               snoop_valid,
  output logic                               snoop_ready,
  input  logic [1:0]                         snoop_op,
  input  logic [i_size-1:0]                  snoop_addr,
  output logic [IW-1:0]                      set_index,
  input  logic [a_size-1:0][TW-1:0]          tag_array,
  input  logic [a_size-1:0][protocol-1:0]    MESI,
  output logic                               wb_req,
  output logic [WW-1:0]                      wb_way,
  output logic [TW-1:0]                      wb_tag,
  input  logic                               wb_ack,
  output logic                               resp_valid,
  output logic [1:0]                         snoop_result,
  output logic                               mesi_we,
  output logic [WW-1:0]                      mesi_way,
  output logic [protocol-1:0]                mesi_new,
  output logic                               proto_err,
  output logic [15:0]                        hit_cnt,
  output logic [15:0]                        hitm_cnt
);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_RWIM  = 2'd1;
  localparam logic [1:0] OP_INV   = 2'd2;
  localparam logic [1:0] OP_WRITE = 2'd3;

  localparam logic [1:0] RES_NOHIT = 2'd0;
  localparam logic [1:0] RES_HIT   = 2'd1;
  localparam logic [1:0] RES_HITM  = 2'd2;

  localparam logic [protocol-1:0] ST_I = protocol'(0);
  localparam logic [protocol-1:0] ST_S = protocol'(1);
  localparam logic [protocol-1:0] ST_E = protocol'(2);
  localparam logic [protocol-1:0] ST_M = protocol'(3);

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, RESPOND} state_t;

  typedef struct packed {
    logic [1:0]          res;
    logic                we;
    logic [protocol-1:0] nst;
    logic                perr;
  } resp_t;

  // MESI transition and response code for a completed lookup
  function automatic resp_t decode(input logic [1:0] op, input logic hit,
                                   input logic [protocol-1:0] st);
    resp_t r;
    r = '0;
    if (hit) begin
      case (op)
        OP_READ: begin
          r.res = (st == ST_M) ? RES_HITM : RES_HIT;
          r.we  = (st != ST_S);
          r.nst = ST_S;
        end
        OP_RWIM: begin
          r.res = (st == ST_M) ? RES_HITM : RES_HIT;
          r.we  = 1'b1;
          r.nst = ST_I;
        end
        OP_INV: begin
          r.res  = RES_HIT;
          r.we   = 1'b1;
          r.nst  = ST_I;
          r.perr = (st == ST_E) || (st == ST_M);
        end
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          op_p0;
  logic [TW-1:0]       tag_p0;
  logic [IW-1:0]       idx_p0;
  logic                hit_p1;
  logic [WW-1:0]       way_p1;
  logic [protocol-1:0] st_p1;

  logic                lk_hit;
  logic [WW-1:0]       lk_way;
  logic [protocol-1:0] lk_st;
  resp_t               rsp;

  logic                unused_addr_bits;
  assign unused_addr_bits = ^snoop_addr[d_size-1:0];

  assign set_index = idx_p0;

  // State register; reset abandons any in-flight request
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---- stage p0: request capture in IDLE ----
  always_ff @(posedge clk) begin
    if (state_q == IDLE && snoop_valid) begin
      op_p0  <= snoop_op;
      tag_p0 <= snoop_addr[i_size-1 -: TW];
    end
  end

  // Captured index drives the tag/MESI store and is a visible output, so it is cleared on reset
  always_ff @(posedge clk) begin
    if (rst)                                 idx_p0 <= '0;
    else if (state_q == IDLE && snoop_valid) idx_p0 <= snoop_addr[d_size +: IW];
  end

  // Hit search: descending scan so the lowest matching way wins; WRITE never hits
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    lk_st  = ST_I;
    for (int i = a_size - 1; i >= 0; i--) begin
      if (MESI[i] != ST_I && tag_array[i] == tag_p0) begin
        lk_hit = 1'b1;
        lk_way = WW'(i);
        lk_st  = MESI[i];
      end
    end
    if (op_p0 == OP_WRITE) lk_hit = 1'b0;
  end

  // ---- stage p1: lookup result registered at the end of LOOKUP ----
  always_ff @(posedge clk) begin
    if (state_q == LOOKUP) begin
      hit_p1 <= lk_hit;
      way_p1 <= lk_way;
      st_p1  <= lk_st;
    end
  end

  assign rsp = decode(op_p0, hit_p1, st_p1);

  // Next-state and output decode; every output is forced low while rst is high
  always_comb begin
    state_d      = state_q;
    snoop_ready  = 1'b0;
    wb_req       = 1'b0;
    wb_way       = '0;
    wb_tag       = '0;
    resp_valid   = 1'b0;
    snoop_result = RES_NOHIT;
    mesi_we      = 1'b0;
    mesi_way     = '0;
    mesi_new     = '0;
    proto_err    = 1'b0;
    case (state_q)
      IDLE: begin
        snoop_ready = !rst;
        if (snoop_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (lk_hit && lk_st == ST_M && (op_p0 == OP_READ || op_p0 == OP_RWIM))
          state_d = WB;
        else
          state_d = RESPOND;
      end
      WB: begin
        wb_req = !rst;
        wb_way = rst ? '0 : way_p1;
        wb_tag = rst ? '0 : tag_p0;
        if (wb_ack) state_d = RESPOND;
      end
      RESPOND: begin
        resp_valid   = !rst;
        snoop_result = rst ? RES_NOHIT : rsp.res;
        mesi_we      = !rst && rsp.we;
        mesi_way     = (!rst && hit_p1) ? way_p1 : '0;
        mesi_new     = (!rst && rsp.we) ? rsp.nst : '0;
        proto_err    = !rst && rsp.perr;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SNOOP_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating hit/hitm statistics, one count per response
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      hitm_cnt <= '0;
    end else if (resp_valid) begin
      if (snoop_result == RES_HIT)  hit_cnt  <= sat_inc(hit_cnt);
      if (snoop_result == RES_HITM) hitm_cnt <= sat_inc(hitm_cnt);
    end
  end
`else
  assign hit_cnt  = '0;
  assign hitm_cnt = '0;
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Testbench for snoop_responder: table-driven snoop vectors with a response
// scoreboard, plus hand-written reset sequences.
module tb_snoop_responder;

  localparam logic [1:0] OP_RD = 2'd0, OP_RWIM = 2'd1, OP_INV = 2'd2, OP_WR = 2'd3;
  localparam logic [1:0] S_I = 2'd0, S_S = 2'd1, S_E = 2'd2, S_M = 2'd3;
  localparam logic [1:0] R_NO = 2'd0, R_HIT = 2'd1, R_HITM = 2'd2;
  localparam logic [31:0] ADDR_A = 32'h0020_0040;  // tag 0x001, set 1
  localparam logic [31:0] ADDR_B = 32'hFFE0_7FC0;  // tag 0x7FF, set 0x1FF

  logic               clk = 1'b0;
  logic               rst;
  logic               snoop_valid;
  logic               snoop_ready;
  logic [1:0]         snoop_op;
  logic [31:0]        snoop_addr;
  logic [14:0]        set_index;
  logic [7:0][10:0]   tag_array;
  logic [7:0][1:0]    MESI;
  logic               wb_req;
  logic [2:0]         wb_way;
  logic [10:0]        wb_tag;
  logic               wb_ack;
  logic               resp_valid;
  logic [1:0]         snoop_result;
  logic               mesi_we;
  logic [2:0]         mesi_way;
  logic [1:0]         mesi_new;
  logic               proto_err;
  logic [15:0]        hit_cnt;
  logic [15:0]        hitm_cnt;

  snoop_responder dut (
    .clk(clk), .rst(rst), .snoop_valid(snoop_valid), .snoop_ready(snoop_ready),
    .snoop_op(snoop_op), .snoop_addr(snoop_addr), .set_index(set_index),
    .tag_array(tag_array), .MESI(MESI), .wb_req(wb_req), .wb_way(wb_way),
    .wb_tag(wb_tag), .wb_ack(wb_ack), .resp_valid(resp_valid),
    .snoop_result(snoop_result), .mesi_we(mesi_we), .mesi_way(mesi_way),
    .mesi_new(mesi_new), .proto_err(proto_err), .hit_cnt(hit_cnt), .hitm_cnt(hitm_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [7:0]  match;    // ways whose tag equals the address tag
    logic [15:0] mesi;
    bit          hold;     // keep snoop_valid high until the response
    bit          early;    // wb_ack high from the lookup cycle on
    int          ack_dly;  // WB cycle in which wb_ack is raised
    logic [1:0]  e_res;
    bit          e_we;
    logic [2:0]  e_way;
    logic [1:0]  e_new;
    bit          e_perr;
    int          e_wb;     // expected number of wb_req cycles
  } vec_t;

  typedef struct {
    logic [1:0] res;
    bit         we;
    logic [2:0] way;
    logic [1:0] nst;
    bit         perr;
  } exp_t;

  vec_t vecs[14];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_hit  = 0;
  int   n_hitm = 0;

  function automatic logic [15:0] st(input int way, input logic [1:0] s);
    logic [15:0] r;
    r = '0;
    r[way*2 +: 2] = s;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    logic [10:0] atag;
    int wbc, lat;
    bit busy_ok, strobe_ok, quiet;
    atag = v.addr[31:21];
    @(negedge clk);
    chk($sformatf("v%0d ready_idle", idx), {31'd0, snoop_ready}, 32'd1);
    for (int w = 0; w < 8; w++) tag_array[w] = v.match[w] ? atag : (atag ^ 11'h005);
    MESI        = v.mesi;
    snoop_op    = v.op;
    snoop_addr  = v.addr;
    snoop_valid = 1'b1;
    e.res = v.e_res; e.we = v.e_we; e.way = v.e_way; e.nst = v.e_new; e.perr = v.e_perr;
    exp_q.push_back(e);
    if (v.e_res == R_HIT)  n_hit++;
    if (v.e_res == R_HITM) n_hitm++;
    @(posedge clk);
    #1;
    if (!v.hold) snoop_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d set_index", idx), {17'd0, set_index}, {17'd0, v.addr[20:6]});
    wbc = 0; lat = -1; busy_ok = 1'b1; strobe_ok = 1'b1;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      if (c > 0) @(negedge clk);
      if ((mesi_we || proto_err) && !resp_valid) strobe_ok = 1'b0;
      if (resp_valid) begin
        lat = c;
        if (exp_q.size() == 0) begin
          chk($sformatf("v%0d unexpected_resp", idx), 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("v%0d result", idx), {30'd0, snoop_result}, {30'd0, e.res});
          chk($sformatf("v%0d mesi_we", idx), {31'd0, mesi_we}, {31'd0, e.we});
          if (e.we) begin
            chk($sformatf("v%0d mesi_way", idx), {29'd0, mesi_way}, {29'd0, e.way});
            chk($sformatf("v%0d mesi_new", idx), {30'd0, mesi_new}, {30'd0, e.nst});
          end
          chk($sformatf("v%0d proto_err", idx), {31'd0, proto_err}, {31'd0, e.perr});
        end
      end else begin
        if (snoop_ready) busy_ok = 1'b0;
        if (wb_req) begin
          wbc++;
          chk($sformatf("v%0d wb_way", idx), {29'd0, wb_way}, {29'd0, v.e_way});
          chk($sformatf("v%0d wb_tag", idx), {21'd0, wb_tag}, {21'd0, atag});
        end
        wb_ack = v.early || (wb_req && wbc == v.ack_dly);
      end
    end
    wb_ack = 1'b0;
    snoop_valid = 1'b0;
    if (lat < 0) begin
      chk($sformatf("v%0d resp_timeout", idx), 32'd1, 32'd0);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      chk($sformatf("v%0d latency", idx), lat, 1 + v.e_wb);
    end
    chk($sformatf("v%0d wb_cycles", idx), wbc, v.e_wb);
    chk($sformatf("v%0d busy_not_ready", idx), {31'd0, busy_ok}, 32'd1);
    chk($sformatf("v%0d strobe_align", idx), {31'd0, strobe_ok}, 32'd1);
    quiet = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid || mesi_we || wb_req) quiet = 1'b0;
    end
    chk($sformatf("v%0d single_resp", idx), {31'd0, quiet}, 32'd1);
  endtask

  initial begin
    bit quiet;
    int guard;
    vecs[0]  = '{OP_RD,   ADDR_A, 8'h08, st(3, S_E),              1'b0, 1'b0, 0, R_HIT,  1'b1, 3'd3, S_S, 1'b0, 0};
    vecs[1]  = '{OP_RWIM, ADDR_A, 8'h08, st(3, S_M),              1'b0, 1'b0, 4, R_HITM, 1'b1, 3'd3, S_I, 1'b0, 4};
    vecs[2]  = '{OP_INV,  ADDR_A, 8'hFF, 16'h0000,                1'b0, 1'b0, 0, R_NO,   1'b0, 3'd0, S_I, 1'b0, 0};
    vecs[3]  = '{OP_INV,  ADDR_A, 8'h10, st(4, S_E),              1'b0, 1'b0, 0, R_HIT,  1'b1, 3'd4, S_I, 1'b1, 0};
    vecs[4]  = '{OP_RWIM, ADDR_A, 8'h24, st(2, S_S) | st(5, S_S), 1'b1, 1'b0, 0, R_HIT,  1'b1, 3'd2, S_I, 1'b0, 0};
    vecs[5]  = '{OP_RD,   ADDR_A, 8'h01, st(0, S_M),              1'b0, 1'b1, 0, R_HITM, 1'b1, 3'd0, S_S, 1'b0, 1};
    vecs[6]  = '{OP_RD,   ADDR_A, 8'h40, st(6, S_S),              1'b0, 1'b0, 0, R_HIT,  1'b0, 3'd6, S_S, 1'b0, 0};
    vecs[7]  = '{OP_WR,   ADDR_A, 8'h02, st(1, S_M),              1'b0, 1'b0, 0, R_NO,   1'b0, 3'd0, S_I, 1'b0, 0};
    vecs[8]  = '{OP_RD,   ADDR_A, 8'h02, st(7, S_E),              1'b0, 1'b0, 0, R_NO,   1'b0, 3'd0, S_I, 1'b0, 0};
    vecs[9]  = '{OP_INV,  ADDR_A, 8'h04, st(2, S_M),              1'b0, 1'b0, 0, R_HIT,  1'b1, 3'd2, S_I, 1'b1, 0};
    vecs[10] = '{OP_INV,  ADDR_A, 8'h02, st(1, S_S),              1'b0, 1'b0, 0, R_HIT,  1'b1, 3'd1, S_I, 1'b0, 0};
    vecs[11] = '{OP_RWIM, ADDR_A, 8'h20, st(5, S_E),              1'b0, 1'b1, 0, R_HIT,  1'b1, 3'd5, S_I, 1'b0, 0};
    vecs[12] = '{OP_RD,   ADDR_B, 8'h80, st(7, S_M),              1'b0, 1'b0, 2, R_HITM, 1'b1, 3'd7, S_S, 1'b0, 2};
    vecs[13] = '{OP_RWIM, ADDR_B, 8'h88, st(7, S_M) | st(3, S_M), 1'b1, 1'b0, 1, R_HITM, 1'b1, 3'd3, S_I, 1'b0, 1};

    rst = 1'b1; snoop_valid = 1'b0; snoop_op = '0; snoop_addr = '0;
    tag_array = '0; MESI = '0; wb_ack = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst ready", {31'd0, snoop_ready}, 32'd0);
    chk("rst outputs", {26'd0, resp_valid, wb_req, mesi_we, proto_err, snoop_result}, 32'd0);
    chk("rst set_index", {17'd0, set_index}, 32'd0);
    chk("rst counters", {hit_cnt, hitm_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after rst", {31'd0, snoop_ready}, 32'd1);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

`ifdef SNOOP_STATS_EN
    chk("hit_cnt", {16'd0, hit_cnt}, n_hit);
    chk("hitm_cnt", {16'd0, hitm_cnt}, n_hitm);
`else
    chk("hit_cnt", {16'd0, hit_cnt}, 32'd0);
    chk("hitm_cnt", {16'd0, hitm_cnt}, 32'd0);
`endif
    chk("queue_drained", exp_q.size(), 32'd0);

    // Reset in the middle of a writeback abandons the request
    @(negedge clk);
    for (int w = 0; w < 8; w++) tag_array[w] = (w == 3) ? 11'h001 : 11'h004;
    MESI = st(3, S_M);
    snoop_op = OP_RWIM; snoop_addr = ADDR_A; snoop_valid = 1'b1;
    @(posedge clk);
    #1 snoop_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!wb_req && guard < 10);
    chk("rst_wb reached", {31'd0, wb_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wb wb_req", {31'd0, wb_req}, 32'd0);
    chk("rst_wb resp", {30'd0, resp_valid, mesi_we}, 32'd0);
    chk("rst_wb ready", {31'd0, snoop_ready}, 32'd0);
    chk("rst_wb counters", {hit_cnt, hitm_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wb ready_after", {31'd0, snoop_ready}, 32'd1);
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mesi_we || wb_req || proto_err) quiet = 1'b0;
    end
    chk("rst_wb no_resp", {31'd0, quiet}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
